// File: rtl/serial_adder_ctrl.sv
// Nibble-serial adder/subtractor: one 4-bit carry-lookahead slice per clock, WIDTH/4 cycles.
// Define SERIAL_ADDER_SUB_EN to honour op_sub; otherwise op_sub is ignored and only A+B is done.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             sub;
    logic [3:0]       sa, sb, p, g, c, sum;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign sub = 1'b0;
`endif

    assign sa = 4'(a_q >> {k_q, 2'b00});
    assign sb = 4'(b_q >> {k_q, 2'b00});

    always_comb begin
        p = sa ^ sb;
        g = sa & sb;
        c[0] = g[0] | (p[0] & carry_q);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        sum = p ^ {c[2:0], carry_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = sub ? ~b : b;
                    carry_d  = sub;
                    k_d      = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                // Target nibble was cleared on accept, so OR-ing the slice in is enough.
                result_d = result_q | (WIDTH'(sum) << {k_q, 2'b00});
                carry_d  = c[3];
                k_d      = k_q + KW'(1);
                if (k_q == KLast) begin
                    cout_d  = c[3];
                    ovf_d   = c[2] ^ c[3];
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes model results, negedge monitor pops on done.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned N = W / 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int           tests = 0;
    int           fails = 0;
    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_res = '0;
    bit           have_last = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .op_sub (op_sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain wide-integer arithmetic; subtraction is A + ~B + 1.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic         eff;
        logic [W-1:0] yy;
        logic [W:0]   full;
        exp_t         e;
`ifdef SERIAL_ADDER_SUB_EN
        eff = s;
`else
        eff = 1'b0;
`endif
        yy    = eff ? ~y : y;
        full  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, eff};
        e.res = full[W-1:0];
        e.co  = full[W];
        e.ov  = (x[W-1] == yy[W-1]) && (e.res[W-1] != x[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic noise_inputs();
        start  = 1'($urandom_range(0, 1));
        a      = $urandom;
        b      = $urandom;
        op_sub = 1'($urandom_range(0, 1));
    endtask

    // Drives one operation from IDLE; returns one cycle after DONE (back in IDLE).
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input bit noise);
        exp_t e;
        int   lat;
        if (have_last) check("result_hold", result, last_res);
        check("idle_before_start", busy, 0);
        e = model(x, y, s);
        sb_q.push_back(e);
        last_res  = e.res;
        have_last = 1'b1;
        a = x;
        b = y;
        op_sub = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        check("busy_after_accept", busy, 1);
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= int'(N) + 4; i++) begin
            if (noise) noise_inputs();
            @(posedge clock);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check("done_latency", lat, N);
        if (noise) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic reset_mid_run();
        a = 32'h1234_5678;
        b = 32'h0F0F_0F0F;
        op_sub = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("busy_mid_run", busy, 1);
        resetn = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clock);
        #1;
        check("rst_hold_busy", busy, 0);
        resetn = 1'b1;
        last_res  = '0;
        have_last = 1'b1;
    endtask

    always @(negedge clock) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)",
                         $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("cout", cout, mon_e.co);
                check("ovf", ovf, mon_e.ov);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("init_busy", busy, 0);
        check("init_done", done, 0);
        check("init_result", result, 0);
        check("init_cout", cout, 0);
        check("init_ovf", ovf, 0);
        resetn = 1'b1;

        do_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        reset_mid_run();
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            do_op(pick(), pick(), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clock);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits; must be a multiple of 4; N = WIDTH/4 slices.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-006 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-007 SHALL have port: op_sub  input  1  1 = A-B, 0 = A+B; sampled with start.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: result  output  WIDTH  sum/difference; held until the next accepted start.
REQ-011 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-012 SHALL have port: ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE, all registered.
REQ-014 SHALL, in IDLE with start=1 at a clock edge, latch A, latch B (inverted when subtracting) and carry = subtract flag, clear slice index k to 0, clear result, cout and ovf, and enter RUN.
REQ-015 SHALL, on each RUN edge, form p = A[4k+3:4k] XOR B[4k+3:4k] and g = A AND B for slice k, and compute all four slice carries by 4-bit carry-lookahead (c[i] = g[i] + p[i]g[i-1] + ... + p[i..0]carry).
REQ-016 SHALL, on each RUN edge, write result[4k+3:4k] = p XOR {c[2:0],carry}, store carry = c[3], and increment k.
REQ-017 SHALL, on the edge that processes k = N-1, set cout = c[3], set ovf = c[2] XOR c[3], and enter DONE.
REQ-018 SHALL drive done=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-019 SHALL assert done N clock edges after the edge that accepted start (8 for WIDTH=32); the next start is accepted no earlier than N+2 edges after the previous accepted start.
REQ-020 SHALL ignore start while busy=1, including during DONE; latched operands SHALL NOT change until the next accepted start.
REQ-021 SHALL keep result, cout and ovf stable from DONE until the next accepted start.
REQ-022 SHALL wrap the result modulo 2^WIDTH; carry out of the top slice appears only on cout.

Reset
REQ-023 SHALL, while resetn=0 (asynchronously, including mid-RUN), force state=IDLE, k=0, carry=0, result=0, cout=0, ovf=0, done=0 and busy=0.
REQ-024 SHALL discard any in-flight operation on reset, SHALL NOT emit done for it, and SHALL accept start on the first edge after resetn rises.

Configuration
REQ-025 SHALL, with macro SERIAL_ADDER_SUB_EN defined, honour op_sub: subtraction latches ~b and an initial carry of 1.
REQ-026 SHALL, without SERIAL_ADDER_SUB_EN, ignore op_sub (treated as 0), always latch b unmodified with initial carry 0, and keep the port list unchanged.

Verification
REQ-027 SHALL verify: a=0x00000001, b=0xFFFFFFFF, op_sub=0 -> 8 edges later done=1 for 1 cycle, result=0x00000000, cout=1, ovf=0.
REQ-028 SHALL verify: a=0x7FFFFFFF, b=0x00000001, op_sub=0 -> result=0x80000000, cout=0, ovf=1.
REQ-029 SHALL verify, with SERIAL_ADDER_SUB_EN: a=5, b=7, op_sub=1 -> result=0xFFFFFFFE, cout=0, ovf=0; without the macro, the same stimulus -> result=0x0000000C.
REQ-030 SHALL verify: start with a=0x12345678, b=0x11111111, then start pulsed during RUN and during DONE with other operands -> a single done, result=0x23456789, no second operation.
REQ-031 SHALL verify: resetn low for 1 cycle at the 4th RUN edge -> all outputs 0 immediately, no done; then a=0xFFFFFFFF, b=0x00000001 -> result=0x00000000, cout=1.
